// File: rtl/tlc_signal_monitor_if.sv
// Lamp-signal bundle between the traffic-light FSM, the safety monitor and the lamp drivers.
// Signals:
//   highwaySignal, farmSignal : lamp codes from the FSM (00 red, 01 yellow, 10 green, 11 illegal)
//   faultClr                  : synchronous fault clear
//   fault, faultCode          : latched fault flag and first-fault code
//   phase                     : tracked lamp phase
//   safeHighway, safeFarm     : gated lamp codes for the drivers
// Modports: master = FSM/driver side, slave = monitor side.
interface tlc_signal_monitor_if;
  logic [1:0] highwaySignal;
  logic [1:0] farmSignal;
  logic       faultClr;
  logic       fault;
  logic [2:0] faultCode;
  logic [2:0] phase;
  logic [1:0] safeHighway;
  logic [1:0] safeFarm;

  modport master (
    output highwaySignal, farmSignal, faultClr,
    input  fault, faultCode, phase, safeHighway, safeFarm
  );

  modport slave (
    input  highwaySignal, farmSignal, faultClr,
    output fault, faultCode, phase, safeHighway, safeFarm
  );
endinterface

// File: rtl/tlc_signal_monitor.sv
// Independent safety checker for the traffic-light controller lamp outputs.
// Tracks the lamp phase sequence (and, optionally, dwell times), latches the first violation
// with a code and forces the registered safe lamp outputs to all-red while faulted.
// Ports:
//   Clk  : clock, rising edge
//   Rst  : synchronous active-high reset
//   mon  : tlc_signal_monitor_if.slave (lamp inputs, faultClr, fault/faultCode/phase, safe lamps)
// Fault codes: 1 illegal code, 2 conflict, 3 illegal transition, 4 wrong green order,
//              5 short yellow, 6 short all-red (lowest code wins).
// Build option: define TLC_MON_TIMING_EN to compile in the dwell counter and codes 5/6.
module tlc_signal_monitor #(
  parameter int unsigned CNT_W      = 31,
  parameter int unsigned MIN_YELLOW = 150000000,
  parameter int unsigned MIN_ALLRED = 50000000
) (
  input logic                 Clk,
  input logic                 Rst,
  tlc_signal_monitor_if.slave mon
);

  typedef enum logic [2:0] {
    PhAllRed  = 3'd0,
    PhHGreen  = 3'd1,
    PhHYellow = 3'd2,
    PhFGreen  = 3'd4,
    PhFYellow = 3'd5
  } phase_e;

  localparam logic GreenHighway = 1'b0;
  localparam logic GreenFarm    = 1'b1;

  // Minimums must be representable in the dwell counter.
  if (((64'(MIN_YELLOW) >> CNT_W) != 64'd0) || ((64'(MIN_ALLRED) >> CNT_W) != 64'd0))
  begin : g_bad_min
    $error("tlc_signal_monitor: minimum dwell exceeds counter range");
  end

  phase_e     phase_q, phase_d;
  logic       next_green_q, next_green_d;
  logic       fault_q, fault_d;
  logic [2:0] code_q, code_d;
  logic [1:0] safe_h_q, safe_h_d;
  logic [1:0] safe_f_q, safe_f_d;

  logic [1:0] h, f;
  phase_e     samp_ph;
  logic [2:0] chk_code;  // 0 = sample accepted
  logic       yellow_ok, allred_ok;
  logic       clr_all, take_same, take_new;

  assign h = mon.highwaySignal;
  assign f = mon.farmSignal;

`ifdef TLC_MON_TIMING_EN
  localparam logic [CNT_W-1:0] MinYellowC = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] MinAllRedC = CNT_W'(MIN_ALLRED);

  logic [CNT_W-1:0] dwell_q, dwell_d;

  // A saturated counter satisfies every minimum.
  assign yellow_ok = (dwell_q >= MinYellowC) || (&dwell_q);
  assign allred_ok = (dwell_q >= MinAllRedC) || (&dwell_q);

  always_comb begin
    dwell_d = dwell_q;
    if (clr_all) begin
      dwell_d = '0;
    end else if (take_new) begin
      dwell_d = CNT_W'(1);
    end else if (take_same && !(&dwell_q)) begin
      dwell_d = dwell_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_d;
    end
  end
`else
  assign yellow_ok = 1'b1;
  assign allred_ok = 1'b1;
`endif

  // Map a pair to its phase; illegal pairs are caught by codes 1/2 before this matters.
  always_comb begin
    case ({h, f})
      4'b1000: samp_ph = PhHGreen;
      4'b0100: samp_ph = PhHYellow;
      4'b0010: samp_ph = PhFGreen;
      4'b0001: samp_ph = PhFYellow;
      default: samp_ph = PhAllRed;
    endcase
  end

  always_comb begin
    chk_code = 3'd0;
    if ((h == 2'b11) || (f == 2'b11)) begin
      chk_code = 3'd1;
    end else if ((h != 2'b00) && (f != 2'b00)) begin
      chk_code = 3'd2;
    end else if (samp_ph != phase_q) begin
      unique case (phase_q)
        PhAllRed: begin
          if (samp_ph == PhHGreen) begin
            if (next_green_q == GreenFarm) chk_code = 3'd4;
            else if (!allred_ok)           chk_code = 3'd6;
          end else if (samp_ph == PhFGreen) begin
            if (next_green_q == GreenHighway) chk_code = 3'd4;
            else if (!allred_ok)              chk_code = 3'd6;
          end else begin
            chk_code = 3'd3;
          end
        end
        PhHGreen: if (samp_ph != PhHYellow) chk_code = 3'd3;
        PhFGreen: if (samp_ph != PhFYellow) chk_code = 3'd3;
        PhHYellow, PhFYellow: begin
          if (samp_ph != PhAllRed) chk_code = 3'd3;
          else if (!yellow_ok)     chk_code = 3'd5;
        end
        default: chk_code = 3'd3;
      endcase
    end
  end

  assign clr_all   = mon.faultClr;
  assign take_same = !clr_all && !fault_q && (chk_code == 3'd0) && (samp_ph == phase_q);
  assign take_new  = !clr_all && !fault_q && (chk_code == 3'd0) && (samp_ph != phase_q);

  always_comb begin
    phase_d      = phase_q;
    next_green_d = next_green_q;
    fault_d      = fault_q;
    code_d       = code_q;
    safe_h_d     = safe_h_q;
    safe_f_d     = safe_f_q;
    if (clr_all) begin
      phase_d      = PhAllRed;
      next_green_d = GreenHighway;
      fault_d      = 1'b0;
      code_d       = 3'd0;
      safe_h_d     = 2'b00;
      safe_f_d     = 2'b00;
    end else if (!fault_q) begin
      if (chk_code != 3'd0) begin
        // Offending pair never reaches the lamps.
        fault_d  = 1'b1;
        code_d   = chk_code;
        safe_h_d = 2'b00;
        safe_f_d = 2'b00;
      end else begin
        safe_h_d = h;
        safe_f_d = f;
        if (take_new) begin
          phase_d = samp_ph;
          if (samp_ph == PhHGreen) next_green_d = GreenFarm;
          if (samp_ph == PhFGreen) next_green_d = GreenHighway;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      phase_q      <= PhAllRed;
      next_green_q <= GreenHighway;
      fault_q      <= 1'b0;
      code_q       <= 3'd0;
      safe_h_q     <= 2'b00;
      safe_f_q     <= 2'b00;
    end else begin
      phase_q      <= phase_d;
      next_green_q <= next_green_d;
      fault_q      <= fault_d;
      code_q       <= code_d;
      safe_h_q     <= safe_h_d;
      safe_f_q     <= safe_f_d;
    end
  end

  assign mon.fault       = fault_q;
  assign mon.faultCode   = code_q;
  assign mon.phase       = phase_q;
  assign mon.safeHighway = safe_h_q;
  assign mon.safeFarm    = safe_f_q;

endmodule
